// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with majority-vote bit sampling.
// Optional break detection is built when UART_RX_BREAK_DETECT_EN is defined.
module uart_rx_os #(
  parameter int CLK_DIV    = 27,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 brk
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] T_MAX = CW'(CLK_DIV - 1);
  localparam logic [SW-1:0] S_LO  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_HI  = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_MAX = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_ONE = SW'(1);
  localparam logic [BW-1:0] B_MAX = BW'(DATA_BITS - 1);
  localparam logic          L_STP = 1'(STOP_BITS - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;
  localparam logic [2:0] ST_BREAK = 3'd5;

  logic                 r_ff1;
  logic                 r_ff2;
  logic [CW-1:0]        r_tcnt;
  logic [SW-1:0]        r_s;
  logic [BW-1:0]        r_bit;
  logic                 r_stop;
  logic [2:0]           r_state;
  logic                 r_v0;
  logic                 r_v1;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit;
  logic                 r_fe;

  logic w_rxs;
  logic w_tick;
  logic w_vote;
  logic w_stop_vote;
  logic w_last;
  logic w_brk_hit;
  logic w_done;
  logic w_par_exp;
  logic w_pe;
  logic w_fe_now;
  logic w_accept;

  assign w_rxs  = r_ff2;
  assign w_tick = (r_tcnt == T_MAX);
  assign w_vote = (r_v0 & r_v1) | (r_v0 & w_rxs) | (r_v1 & w_rxs);

  assign w_stop_vote = w_tick && (r_state == ST_STOP) && (r_s == S_HI);
  assign w_last      = (r_stop == L_STP);
  assign w_done      = w_stop_vote && w_last && !w_brk_hit;
  assign w_par_exp   = (PARITY == 2) ? ^r_shift : ~^r_shift;
  assign w_pe        = (PARITY != 0) && (r_par_bit != w_par_exp);
  assign w_fe_now    = r_fe | ~w_vote;
  assign w_accept    = rx_valid & rx_ready;

`ifdef UART_RX_BREAK_DETECT_EN
  assign w_brk_hit = w_stop_vote && !r_stop && !w_vote &&
                     (r_shift == '0) &&
                     ((PARITY == 0) || !r_par_bit);
`else
  assign w_brk_hit = 1'b0;
  assign brk       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ff1 <= 1'b1;
      r_ff2 <= 1'b1;
    end else begin
      r_ff1 <= rx;
      r_ff2 <= r_ff1;
    end
  end

  // Free-running: never realigned to the start edge.
  always_ff @(posedge clk) begin
    if (rst)         r_tcnt <= '0;
    else if (w_tick) r_tcnt <= '0;
    else             r_tcnt <= r_tcnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_s       <= '0;
      r_bit     <= '0;
      r_stop    <= 1'b0;
      r_v0      <= 1'b0;
      r_v1      <= 1'b0;
      r_shift   <= '0;
      r_par_bit <= 1'b0;
      r_fe      <= 1'b0;
    end else if (w_tick) begin
      case (r_state)
        ST_IDLE: begin
          // The detecting tick is sample 0 of the start bit.
          if (!w_rxs) begin
            r_state <= ST_START;
            r_s     <= S_ONE;
            r_bit   <= '0;
            r_stop  <= 1'b0;
            r_fe    <= 1'b0;
          end
        end
        ST_BREAK: begin
          if (w_rxs) r_state <= ST_IDLE;
        end
        default: begin
          r_s <= (r_s == S_MAX) ? '0 : r_s + 1'b1;
          if (r_s == S_LO)  r_v0 <= w_rxs;
          if (r_s == S_MID) r_v1 <= w_rxs;
          case (r_state)
            ST_START: begin
              if (r_s == S_HI && w_vote)
                r_state <= ST_IDLE;
              else if (r_s == S_MAX)
                r_state <= ST_DATA;
            end
            ST_DATA: begin
              if (r_s == S_HI)
                r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
              if (r_s == S_MAX) begin
                if (r_bit == B_MAX) begin
                  r_bit   <= '0;
                  r_state <= (PARITY != 0) ? ST_PAR : ST_STOP;
                end else begin
                  r_bit <= r_bit + 1'b1;
                end
              end
            end
            ST_PAR: begin
              if (r_s == S_HI)  r_par_bit <= w_vote;
              if (r_s == S_MAX) r_state   <= ST_STOP;
            end
            ST_STOP: begin
              if (r_s == S_HI) begin
                if (!w_vote) r_fe <= 1'b1;
                if (w_brk_hit)   r_state <= ST_BREAK;
                else if (w_last) r_state <= ST_IDLE;
              end
              if (r_s == S_MAX && !w_last) r_stop <= 1'b1;
            end
            default: r_state <= ST_IDLE;
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
      if (w_accept) rx_valid <= 1'b0;
      if (w_brk_hit) begin
        frame_err <= 1'b1;
      end else if (w_done) begin
        frame_err  <= w_fe_now;
        parity_err <= w_pe;
        if (!rx_valid || rx_ready) begin
          rx_data  <= r_shift;
          rx_valid <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end
    end
  end

`ifdef UART_RX_BREAK_DETECT_EN
  logic r_brk;

  always_ff @(posedge clk) begin
    if (rst) r_brk <= 1'b0;
    else     r_brk <= w_brk_hit;
  end

  assign brk = r_brk;
`endif

endmodule
